// File: rtl/blake2_ctrl_pkg.sv
// Widths and reader state encoding shared by the Blake2 input controller and
// the digest reader, so both ends of the engine agree on word packing.
package blake2_ctrl_pkg;

  localparam int DIGEST_WIDTH_DEF = 512;
  localparam int BUS_WIDTH_DEF    = 64;

  typedef enum logic {
    IDLE,
    STREAM
  } reader_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is high in the cycle where d is high
// and was low at the previous clock edge.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/digest_reader.sv
// Captures the hash engine digest on the rising edge of digest_valid and
// streams it out word 0 first over a valid/ready handshake.
module digest_reader
  import blake2_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
  parameter int DIGEST_WIDTH = DIGEST_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic                    digest_valid,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    read_done,
  output logic                    reader_idle,
  input  logic                    abort,
  input  logic                    clear_err,
  output logic                    overrun_err
);

  localparam int WORDS = DIGEST_WIDTH / BUS_WIDTH;
  localparam int IDX_W = $clog2(WORDS);

  reader_state_t               state_q, state_d;
  logic [DIGEST_WIDTH-1:0]     buf_q, buf_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        read_done_q, read_done_d;
  logic                        overrun_q, overrun_d;
  logic                        rise;
  logic                        xfer;
  logic                        last_word;
  logic [WORDS-1:0][BUS_WIDTH-1:0] words;

  rise_detect u_rise_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (digest_valid),
    .rise    (rise)
  );

  // Word 0 sits in the least significant bits, matching the controller's packing.
  assign words      = buf_q;
  assign dout       = words[idx_q];
  assign dout_valid = (state_q == STREAM);
  assign xfer       = dout_valid & dout_ready;
  assign last_word  = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    read_done_d = 1'b0;
    overrun_d   = overrun_q & ~clear_err;

    if (abort) begin
      state_d = IDLE;
      buf_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = STREAM;
            buf_d   = digest;
            idx_d   = '0;
          end
        end
        STREAM: begin
          if (xfer && last_word) begin
            read_done_d = 1'b1;
            idx_d       = '0;
            // A digest arriving exactly as the last word leaves is not an overrun.
            if (rise) begin
              buf_d = digest;
            end else begin
              state_d = IDLE;
              buf_d   = '0;
            end
          end else begin
            if (xfer) idx_d = idx_q + IDX_W'(1);
            if (rise) overrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the digest buffer is reset along with the control state so dout
  // reads zero out of reset and after an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      read_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      read_done_q <= read_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign read_done   = read_done_q;
  assign reader_idle = (state_q == IDLE);
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_digest_reader.sv
// Directed bench for digest_reader: inputs change and outputs are sampled on
// the falling clock edge, half a cycle away from the capturing edge.
module tb_digest_reader;

  localparam logic [63:0] M1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] M2 = 64'h0123_4567_89AB_CDEF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] digest;
  logic         digest_valid;
  logic [63:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         read_done;
  logic         reader_idle;
  logic         abort;
  logic         clear_err;
  logic         overrun_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  digest_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .digest       (digest),
    .digest_valid (digest_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .read_done    (read_done),
    .reader_idle  (reader_idle),
    .abort        (abort),
    .clear_err    (clear_err),
    .overrun_err  (overrun_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word i of a test digest is mult*(i+1).
  function automatic logic [63:0] wd(input logic [63:0] mult, input int i);
    return 64'(mult * 64'(i + 1));
  endfunction

  function automatic logic [511:0] mk(input logic [63:0] mult);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = wd(mult, i);
    return d;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dout"},    dout,        64'h0);
    check({tag, "_valid"},   dout_valid,  64'h0);
    check({tag, "_done"},    read_done,   64'h0);
    check({tag, "_idle"},    reader_idle, 64'h1);
    check({tag, "_overrun"}, overrun_err, 64'h0);
  endtask

  // Expects word `from` of digest mult on dout now, with ready held high.
  task automatic drain(input string tag, input logic [63:0] mult, input int from);
    for (int i = from; i < 8; i++) begin
      check($sformatf("%s_w%0d", tag, i), dout, wd(mult, i));
      check($sformatf("%s_v%0d", tag, i), dout_valid, 64'h1);
      step();
    end
    check({tag, "_done"}, read_done, 64'h1);
    check({tag, "_idle"}, reader_idle, 64'h1);
  endtask

  initial begin
    int k;
    int c;
    logic [3:0] pat;

    reset_n      = 1'b0;
    digest       = '0;
    digest_valid = 1'b0;
    dout_ready   = 1'b0;
    abort        = 1'b0;
    clear_err    = 1'b0;
    step();
    check_reset_values("rst");
    reset_n = 1'b1;
    step();

    // 1: basic read, digest_valid left high throughout
    digest = mk(M1); digest_valid = 1'b1; dout_ready = 1'b1;
    step();
    drain("basic", M1, 0);
    check("basic_valid_off", dout_valid, 64'h0);
    step();
    check("basic_done_once", read_done, 64'h0);
    check("basic_no_retrig", dout_valid, 64'h0);
    digest_valid = 1'b0;
    step();

    // 2: backpressure with ready pattern 1,0,0,1
    digest = mk(M2); digest_valid = 1'b1; dout_ready = 1'b0;
    step();
    digest_valid = 1'b0;
    pat = 4'b1001;
    k = 0; c = 0;
    while (k < 8 && c < 40) begin
      check($sformatf("bp_w%0d_c%0d", k, c), dout, wd(M2, k));
      check($sformatf("bp_v_c%0d", c), dout_valid, 64'h1);
      check($sformatf("bp_nodone_c%0d", c), read_done, 64'h0);
      dout_ready = pat[c % 4];
      step();
      if (dout_ready) k++;
      c++;
    end
    check("bp_transfers", 64'(k), 64'd8);
    check("bp_cycles", 64'(c), 64'd16);
    check("bp_done", read_done, 64'h1);
    dout_ready = 1'b1;
    step();

    // 3: overrun after three transfers, then clear
    digest = mk(M1); digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ovr_w%0d", i), dout, wd(M1, i));
      step();
    end
    digest = mk(M2); digest_valid = 1'b1; dout_ready = 1'b0;
    step();
    check("ovr_set", overrun_err, 64'h1);
    check("ovr_hold_w3", dout, wd(M1, 3));
    digest_valid = 1'b0; clear_err = 1'b1; dout_ready = 1'b1;
    step();
    check("ovr_cleared", overrun_err, 64'h0);
    clear_err = 1'b0;
    drain("ovr", M1, 4);
    step();

    // 4: back-to-back, second rise with the final transfer
    digest = mk(M1); digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("b2b_w%0d", i), dout, wd(M1, i));
      step();
    end
    check("b2b_w7", dout, wd(M1, 7));
    digest = mk(M2); digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check("b2b_done", read_done, 64'h1);
    check("b2b_no_ovr", overrun_err, 64'h0);
    check("b2b_busy", reader_idle, 64'h0);
    drain("b2b2", M2, 0);
    step();

    // 5: abort after two words
    digest = mk(M1); digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check("ab_w0", dout, wd(M1, 0));
    step();
    check("ab_w1", dout, wd(M1, 1));
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", dout_valid, 64'h0);
    check("ab_idle", reader_idle, 64'h1);
    check("ab_done0", read_done, 64'h0);
    check("ab_dout", dout, 64'h0);
    step();
    check("ab_done1", read_done, 64'h0);
    digest = mk(M2); digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ab2_w%0d", i), dout, wd(M2, i));
      step();
    end

    // 6: asynchronous reset at word 4, digest_valid then held high
    check("rs_w4", dout, wd(M2, 4));
    digest = mk(M1); digest_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_values("rs_async");
    step();
    reset_n = 1'b1;
    step();
    drain("rs_cap", M1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rs_once_%0d", i), dout_valid, 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
